// File: rtl/fetch_unit.sv
//==============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage with PC, local control transfers
//               (GOTO/CALL/RETURN) on a circular return stack, and skip squash.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_unit #(
    parameter int PC_W         = 8,
    parameter int STACK_DEPTH  = 2,
    parameter int RESET_VECTOR = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            skip_req,
    output logic [PC_W-1:0] pm_addr,
    input  logic [15:0]     pm_data,
    output logic [7:0]      inst_reg,
    output logic [7:0]      operand,
    output logic            inst_valid,
    output logic            stack_err
);

    localparam int                c_SP_W   = $clog2(STACK_DEPTH);
    localparam int                c_CNT_W  = 8;
    localparam logic [PC_W-1:0]   c_RST_PC = PC_W'(RESET_VECTOR);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(STACK_DEPTH);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [PC_W-1:0]     r_pc, w_pc_nxt, w_pc_inc;
    logic [7:0]          r_inst, w_inst_nxt;
    logic [7:0]          r_opnd, w_opnd_nxt;
    logic                r_valid, w_valid_nxt;
    logic                r_skip;
    logic                r_err;
    logic [15:0]         r_hold;
    logic                r_held;
    logic [15:0]         w_word;
    logic                w_load, w_push, w_pop;
    logic [PC_W-1:0]     r_stack [STACK_DEPTH];
    logic [c_SP_W-1:0]   r_sp, w_sp_dec;
    // Nesting depth, kept beyond STACK_DEPTH so returns keep unwinding the
    // circular buffer after an overflow until the true depth reaches zero.
    logic [c_CNT_W-1:0]  r_cnt;

    assign pm_addr    = r_pc;
    assign inst_reg   = r_inst;
    assign operand    = r_opnd;
    assign inst_valid = r_valid;
    assign stack_err  = r_err;

    // While stalled, memory re-reads pc, so the word for pc-1 is parked here.
    assign w_word   = r_held ? r_hold : pm_data;
    assign w_pc_inc = r_pc + 1'b1;
    assign w_sp_dec = r_sp - 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_inst_nxt  = r_inst;
        w_opnd_nxt  = r_opnd;
        w_valid_nxt = r_valid;
        w_load      = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        if (!stall) begin
            case (r_state)
                S_FILL: begin
                    w_inst_nxt  = 8'h00;
                    w_valid_nxt = 1'b0;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = S_RUN;
                end
                default: begin
                    w_load     = 1'b1;
                    w_pc_nxt   = w_pc_inc;
                    w_opnd_nxt = w_word[7:0];
                    if (r_skip) begin
                        w_inst_nxt  = 8'h00;
                        w_valid_nxt = 1'b0;
                    end else if (w_word[15:14] == 2'b10) begin
                        w_inst_nxt  = 8'h00;
                        w_valid_nxt = 1'b0;
                        case (w_word[13:12])
                            2'b00: begin
                                w_pc_nxt    = w_word[PC_W-1:0];
                                w_state_nxt = S_FILL;
                            end
                            2'b01: begin
                                w_push      = 1'b1;
                                w_pc_nxt    = w_word[PC_W-1:0];
                                w_state_nxt = S_FILL;
                            end
                            2'b10: begin
                                w_pop       = 1'b1;
                                w_pc_nxt    = (r_cnt == '0) ? c_RST_PC : r_stack[w_sp_dec];
                                w_state_nxt = S_FILL;
                            end
                            default: ;
                        endcase
                    end else begin
                        w_inst_nxt  = w_word[15:8];
                        w_valid_nxt = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
            r_pc    <= c_RST_PC;
            r_inst  <= 8'h00;
            r_opnd  <= 8'h00;
            r_valid <= 1'b0;
            r_skip  <= 1'b0;
            r_err   <= 1'b0;
            r_hold  <= 16'h0000;
            r_held  <= 1'b0;
            r_sp    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_inst  <= w_inst_nxt;
            r_opnd  <= w_opnd_nxt;
            r_valid <= w_valid_nxt;
            r_skip  <= skip_req | (r_skip & ~w_load);
            if (stall) begin
                if (!r_held) begin
                    r_hold <= pm_data;
                    r_held <= 1'b1;
                end
            end else begin
                r_held <= 1'b0;
            end
            if (w_push) begin
                r_sp <= r_sp + 1'b1;
                if (r_cnt >= c_FULL) begin
                    r_err <= 1'b1;
                end
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_pop) begin
                if (r_cnt == '0) begin
                    r_err <= 1'b1;
                end else begin
                    r_sp  <= w_sp_dec;
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[r_sp] <= r_pc;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//==============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard bench for fetch_unit with a synchronous program RAM.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        skip_req = 1'b0;
    logic [7:0]  pm_addr;
    logic [15:0] pm_data = 16'h0000;
    logic [7:0]  inst_reg;
    logic [7:0]  operand;
    logic        inst_valid;
    logic        stack_err;

    logic [15:0] mem [256];
    logic [15:0] exp_q [$];
    logic        edge_live = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    fetch_unit #(.PC_W(8), .STACK_DEPTH(2), .RESET_VECTOR(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .skip_req   (skip_req),
        .pm_addr    (pm_addr),
        .pm_data    (pm_data),
        .inst_reg   (inst_reg),
        .operand    (operand),
        .inst_valid (inst_valid),
        .stack_err  (stack_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pm_data <= mem[pm_addr];
    always @(posedge clk) edge_live = !stall;

    task automatic ck(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: each freshly loaded valid instruction must match the queue head.
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_n && edge_live && inst_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL inst_unexpected: got 0x%0h expected none", {inst_reg, operand});
            end else begin
                e = exp_q.pop_front();
                ck("inst_seq", int'({inst_reg, operand}), int'(e));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_addr(input int a, input string name);
        int k = 0;
        do begin
            step();
            k++;
        end while (int'(pm_addr) != a && k < 60);
        ck(name, int'(pm_addr), a);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    initial begin
        // ---------------- Phase A: sequential, GOTO, CALL/RETURN, stack wrap
        clear_mem();
        mem[8'h00] = 16'h2800; mem[8'h01] = 16'h0C05; mem[8'h02] = 16'h0102;
        mem[8'h03] = 16'h8040; mem[8'h04] = 16'h0404;
        mem[8'h40] = 16'h1140; mem[8'h41] = 16'h8005;
        mem[8'h05] = 16'h9010; mem[8'h10] = 16'hA000;
        mem[8'h06] = 16'h0606; mem[8'h07] = 16'h9020;
        mem[8'h20] = 16'h9030; mem[8'h30] = 16'h9050;
        mem[8'h50] = 16'h5050; mem[8'h51] = 16'hA000;
        mem[8'h31] = 16'h3131; mem[8'h32] = 16'hA000;
        mem[8'h21] = 16'h2121; mem[8'h22] = 16'hA000;
        exp_q.push_back(16'h2800); exp_q.push_back(16'h0C05);
        exp_q.push_back(16'h0102); exp_q.push_back(16'h1140);
        exp_q.push_back(16'h0606); exp_q.push_back(16'h5050);
        exp_q.push_back(16'h3131); exp_q.push_back(16'h2121);
        exp_q.push_back(16'h3131);

        @(negedge clk);
        @(negedge clk);
        ck("rst_pm_addr", int'(pm_addr), 0);
        ck("rst_inst_reg", int'(inst_reg), 0);
        ck("rst_operand", int'(operand), 0);
        ck("rst_inst_valid", int'(inst_valid), 0);
        ck("rst_stack_err", int'(stack_err), 0);
        rst_n = 1'b1;
        step();
        ck("c1_valid", int'(inst_valid), 0);
        ck("c1_pm_addr", int'(pm_addr), 1);
        step();
        ck("c2_inst", int'({inst_reg, operand}), 'h2800);
        ck("c2_pm_addr", int'(pm_addr), 2);
        step();
        ck("c3_inst", int'({inst_reg, operand}), 'h0C05);
        ck("c3_pm_addr", int'(pm_addr), 3);

        wait_addr('h40, "goto_target");
        ck("goto_bubble1_valid", int'(inst_valid), 0);
        ck("goto_bubble1_inst", int'(inst_reg), 0);
        step();
        ck("goto_bubble2_valid", int'(inst_valid), 0);
        ck("goto_fill_pm_addr", int'(pm_addr), 'h41);
        step();
        ck("goto_first_inst", int'({inst_valid, inst_reg}), 'h111);

        wait_addr('h10, "call_target");
        ck("call_err", int'(stack_err), 0);
        wait_addr('h06, "return_addr");
        ck("return_err", int'(stack_err), 0);
        wait_addr('h20, "nest_call1");
        wait_addr('h30, "nest_call2");
        ck("nest2_err", int'(stack_err), 0);
        wait_addr('h50, "nest_call3");
        ck("overflow_err", int'(stack_err), 1);
        wait_addr('h31, "ret_third");
        wait_addr('h21, "ret_second");
        wait_addr('h31, "ret_overwritten");
        wait_addr('h00, "underflow_vector");
        ck("underflow_err", int'(stack_err), 1);
        ck("underflow_valid", int'(inst_valid), 0);
        ck("queue_drained_a", exp_q.size(), 0);

        // ---------------- Phase B: skip over GOTO, stall with skip inside
        rst_n = 1'b0;
        clear_mem();
        mem[0] = 16'h0101; mem[1] = 16'h0202; mem[2] = 16'h8020;
        mem[3] = 16'h0303; mem[4] = 16'h0404; mem[5] = 16'h0505;
        mem[6] = 16'h0606; mem[7] = 16'h0707; mem[8] = 16'h9040;
        mem[8'h40] = 16'h4444;
        exp_q.push_back(16'h0101); exp_q.push_back(16'h0202);
        exp_q.push_back(16'h0303); exp_q.push_back(16'h0505);
        exp_q.push_back(16'h0606); exp_q.push_back(16'h0707);
        #1;
        ck("rst_clears_err", int'(stack_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_addr(2, "b_start");
        skip_req = 1'b1;
        step();
        skip_req = 1'b0;
        step();
        ck("skip_valid", int'(inst_valid), 0);
        ck("skip_no_redirect", int'(pm_addr), 4);
        step();
        ck("pre_stall_pm_addr", int'(pm_addr), 5);
        stall = 1'b1;
        step();
        ck("stall1_pm_addr", int'(pm_addr), 5);
        ck("stall1_inst", int'({inst_valid, inst_reg, operand}), 'h10303);
        skip_req = 1'b1;
        step();
        skip_req = 1'b0;
        ck("stall2_pm_addr", int'(pm_addr), 5);
        ck("stall2_inst", int'({inst_valid, inst_reg, operand}), 'h10303);
        step();
        ck("stall3_pm_addr", int'(pm_addr), 5);
        stall = 1'b0;
        step();
        ck("post_stall_squash", int'(inst_valid), 0);
        ck("post_stall_pm_addr", int'(pm_addr), 6);

        // ---------------- Phase C: reset during the FILL after a CALL
        wait_addr('h40, "b_call_target");
        ck("b_call_err", int'(stack_err), 0);
        rst_n = 1'b0;
        mem[0] = 16'hA000;
        #1;
        ck("async_rst_pm_addr", int'(pm_addr), 0);
        ck("async_rst_operand", int'(operand), 0);
        ck("async_rst_inst", int'({inst_valid, inst_reg}), 0);
        ck("queue_drained_b", exp_q.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        ck("c_fill_pm_addr", int'(pm_addr), 1);
        step();
        ck("c_empty_stack_err", int'(stack_err), 1);
        ck("c_underflow_pm_addr", int'(pm_addr), 0);
        ck("c_underflow_valid", int'(inst_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
